// File: rtl/score_pkg.sv
// Shared constants, FSM encoding and double-dabble helpers for the score display path.
package score_pkg;

  localparam int SCORE_W        = 32;
  localparam int BCD_INT_DIGITS = 10;
  localparam int BCD_INT_W      = 4 * BCD_INT_DIGITS;

  // Active-low segment patterns, bit order {g,f,e,d,c,b,a}.
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Add-3 correction for one BCD nibble before it is doubled by the shift.
  function automatic logic [3:0] dd_adjust(input logic [3:0] nib);
    logic [3:0] res;
    if (nib >= 4'd5) begin
      res = nib + 4'd3;
    end else begin
      res = nib;
    end
    return res;
  endfunction

  // One double-dabble iteration: correct every nibble, then shift in_bit in at the bottom.
  function automatic logic [BCD_INT_W-1:0] dd_step(input logic [BCD_INT_W-1:0] bcd,
                                                   input logic                 in_bit);
    logic [BCD_INT_W:0] wide;
    for (int i = 0; i < BCD_INT_DIGITS; i++) begin
      wide[4*i+1 +: 4] = dd_adjust(bcd[4*i +: 4]);
    end
    wide[0] = in_bit;
    return wide[BCD_INT_W-1:0];
  endfunction

endpackage

// File: rtl/score_display_bcd_to_7seg.sv
// Combinational BCD nibble to active-low seven-segment decoder with a blank override.
module bcd_to_7seg
  import score_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       blank,
  output logic [6:0] segs
);

  // Map the nibble to its segment pattern; non-decimal codes and blanked digits go dark.
  always_comb begin
    segs = SEG_BLANK;
    if (blank) begin
      segs = SEG_BLANK;
    end else begin
      case (nibble)
        4'd0:    segs = SEG_0;
        4'd1:    segs = SEG_1;
        4'd2:    segs = SEG_2;
        4'd3:    segs = SEG_3;
        4'd4:    segs = SEG_4;
        4'd5:    segs = SEG_5;
        4'd6:    segs = SEG_6;
        4'd7:    segs = SEG_7;
        4'd8:    segs = SEG_8;
        4'd9:    segs = SEG_9;
        default: segs = SEG_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/score_display.sv
// Watches the running score, converts it to BCD one bit per cycle and drives the digit displays.
module score_display
  import score_pkg::*;
#(
  parameter int NUM_DIGITS = 8,
  parameter bit BLANK_LZ   = 1'b1
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [SCORE_W-1:0]      score,
  output logic [4*NUM_DIGITS-1:0] digits_bcd,
  output logic [7*NUM_DIGITS-1:0] hex_segs,
  output logic                    busy,
  output logic                    update,
  output logic                    overflow
);

  localparam int DW = 4 * NUM_DIGITS;
  localparam int SW = 7 * NUM_DIGITS;

  // Display pattern for a value of zero: digit 0 lit, the rest blank when blanking is on.
  function automatic logic [SW-1:0] reset_segs();
    logic [SW-1:0] r;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      r[7*i +: 7] = ((i == 0) || !BLANK_LZ) ? SEG_0 : SEG_BLANK;
    end
    return r;
  endfunction

  localparam logic [SW-1:0] SEGS_RST = reset_segs();

  state_t                 state_q, state_d;
  logic [SCORE_W-1:0]     last_score_q, last_score_d;
  logic [SCORE_W-1:0]     shift_q, shift_d;
  logic [BCD_INT_W-1:0]   bcd_q, bcd_d;
  logic [5:0]             cnt_q, cnt_d;
  logic [DW-1:0]          digits_q, digits_d;
  logic [SW-1:0]          segs_q, segs_d;
  logic                   busy_q, busy_d;
  logic                   update_q, update_d;
  logic                   overflow_q, overflow_d;

  logic                   ovf_s;
  logic                   zero_run_s;
  logic [DW-1:0]          digits_new_s;
  logic [NUM_DIGITS-1:0]  blank_s;
  logic [SW-1:0]          segs_new_s;

  // Saturate the finished BCD value to the display width, flagging anything that does not fit.
  always_comb begin
    ovf_s        = 1'b0;
    digits_new_s = '0;
    for (int i = 0; i < BCD_INT_DIGITS; i++) begin
      if (i >= NUM_DIGITS) begin
        ovf_s = ovf_s | (bcd_q[4*i +: 4] != 4'd0);
      end else begin
        ovf_s = ovf_s;
      end
    end
    for (int i = 0; i < NUM_DIGITS; i++) begin
      digits_new_s[4*i +: 4] = ovf_s ? 4'd9 : bcd_q[4*i +: 4];
    end
  end

  // Blank a digit when it and every digit above it are zero; digit 0 always stays lit.
  always_comb begin
    zero_run_s = 1'b1;
    blank_s    = '0;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      zero_run_s = zero_run_s & (digits_new_s[4*i +: 4] == 4'd0);
      blank_s[i] = BLANK_LZ & ~ovf_s & zero_run_s;
    end
  end

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dec
    bcd_to_7seg u_dec (
      .nibble (digits_new_s[4*g +: 4]),
      .blank  (blank_s[g]),
      .segs   (segs_new_s[7*g +: 7])
    );
  end

  // Conversion FSM next-state: capture a changed score, run 32 shift-add-3 steps, publish.
  always_comb begin
    state_d      = state_q;
    last_score_d = last_score_q;
    shift_d      = shift_q;
    bcd_d        = bcd_q;
    cnt_d        = cnt_q;
    digits_d     = digits_q;
    segs_d       = segs_q;
    busy_d       = busy_q;
    update_d     = 1'b0;
    overflow_d   = overflow_q;
    case (state_q)
      IDLE: begin
        if (score != last_score_q) begin
          shift_d      = score;
          last_score_d = score;
          bcd_d        = '0;
          cnt_d        = 6'd0;
          busy_d       = 1'b1;
          state_d      = SHIFT;
        end else begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      SHIFT: begin
        bcd_d   = dd_step(bcd_q, shift_q[SCORE_W-1]);
        shift_d = {shift_q[SCORE_W-2:0], 1'b0};
        cnt_d   = cnt_q + 6'd1;
        busy_d  = 1'b1;
        if (cnt_q == 6'd31) begin
          state_d = DONE;
        end else begin
          state_d = SHIFT;
        end
      end
      DONE: begin
        digits_d   = digits_new_s;
        segs_d     = segs_new_s;
        overflow_d = ovf_s;
        update_d   = 1'b1;
        busy_d     = 1'b1;
        state_d    = IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      last_score_q <= '0;
      shift_q      <= '0;
      bcd_q        <= '0;
      cnt_q        <= 6'd0;
      digits_q     <= '0;
      segs_q       <= SEGS_RST;
      busy_q       <= 1'b0;
      update_q     <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_score_q <= last_score_d;
      shift_q      <= shift_d;
      bcd_q        <= bcd_d;
      cnt_q        <= cnt_d;
      digits_q     <= digits_d;
      segs_q       <= segs_d;
      busy_q       <= busy_d;
      update_q     <= update_d;
      overflow_q   <= overflow_d;
    end
  end

  assign digits_bcd = digits_q;
  assign hex_segs   = segs_q;
  assign busy       = busy_q;
  assign update     = update_q;
  assign overflow   = overflow_q;

endmodule
